// File: rtl/imem_loader_if.sv
// Host/core-side bus of the instruction-memory loader.
// master: host + core fetch side; slave: the loader itself.
interface imem_loader_if #(
  parameter int AW = 6
);
  logic          start;
  logic [AW:0]   len;
  logic          wvalid;
  logic [31:0]   wdata;
  logic          wready;
  logic [31:0]   core_a;
  logic [31:0]   mem_a;
  logic          mem_we;
  logic [31:0]   mem_wd;
  logic          core_reset;
  logic          done;
  logic          err;

  modport master (
    output start, len, wvalid, wdata, core_a,
    input  wready, mem_a, mem_we, mem_wd, core_reset, done, err
  );

  modport slave (
    input  start, len, wvalid, wdata, core_a,
    output wready, mem_a, mem_we, mem_wd, core_reset, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams a host program into IMEM while holding
// the core in reset, then muxes the memory address back to the core fetch.
// Optional IMEM_LOAD_CHECKSUM_EN: after the program, the host sends one extra
// word that must equal the mod-2^32 sum of the program words.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input logic        clk,
  input logic        reset,
  imem_loader_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
`ifdef IMEM_LOAD_CHECKSUM_EN
    CHECK = 2'd2,
`endif
    RUN   = 2'd3
  } state_t;

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_t        r_state, w_next;
  logic [AW-1:0] r_cnt;
  logic [AW:0]   r_len;
  logic          r_err;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0]   r_sum;
`endif

  logic          w_len_ok, w_can_start, w_start_ok, w_start_bad, w_last;
  logic          w_wready, w_mem_we, w_core_reset, w_done;
  logic [31:0]   w_mem_a;

  assign w_len_ok    = (bus.len != '0) && (bus.len <= LEN_MAX);
  // start is only honoured when no load/check is in flight
  assign w_can_start = (r_state == IDLE) || (r_state == RUN);
  assign w_start_ok  = bus.start & w_can_start & w_len_ok;
  assign w_start_bad = bus.start & w_can_start & ~w_len_ok;
  assign w_last      = ({1'b0, r_cnt} == (r_len - 1'b1));

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // next-state and bus outputs; memory port belongs to the core outside LOAD
  always_comb begin
    w_next       = r_state;
    w_wready     = 1'b0;
    w_core_reset = 1'b1;
    w_done       = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_a      = bus.core_a;
    case (r_state)
      IDLE: if (w_start_ok) w_next = LOAD;
      LOAD: begin
        w_wready = 1'b1;
        w_mem_we = bus.wvalid;
        w_mem_a  = 32'({r_cnt, 2'b00});
        if (bus.wvalid && w_last)
`ifdef IMEM_LOAD_CHECKSUM_EN
          w_next = CHECK;
`else
          w_next = RUN;
`endif
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      CHECK: begin
        w_wready = 1'b1;
        if (bus.wvalid) w_next = (bus.wdata == r_sum) ? RUN : IDLE;
      end
`endif
      RUN: begin
        w_core_reset = 1'b0;
        w_done       = 1'b1;
        if (w_start_ok) w_next = LOAD;
      end
      default: w_next = IDLE;
    endcase
  end

  // word counter, latched length, error flag (and running checksum)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_len <= '0;
      r_err <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      r_sum <= '0;
`endif
    end else begin
      if (w_start_ok) begin
        r_len <= bus.len;
        r_cnt <= '0;
        r_err <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
        r_sum <= '0;
`endif
      end else if (w_start_bad) begin
        r_err <= 1'b1;
      end
      if (r_state == LOAD && bus.wvalid) begin
        // hold at len-1 on the final word so the counter never wraps
        if (!w_last) r_cnt <= r_cnt + 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
        r_sum <= r_sum + bus.wdata;
`endif
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      if (r_state == CHECK && bus.wvalid && bus.wdata != r_sum) r_err <= 1'b1;
`endif
    end
  end

  assign bus.wready     = w_wready;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_a      = w_mem_a;
  assign bus.mem_wd     = bus.wdata;
  assign bus.core_reset = w_core_reset;
  assign bus.done       = w_done;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Inputs are driven on the falling edge,
// outputs sampled 1-2 time units later. A behavioural IMEM array captures the
// writes; each program is checked word-by-word against what was sent.
module tb_imem_loader;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if #(.AW(AW)) bus();
  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  int n_we  = 0;
  logic [31:0] bmem [DEPTH];
  logic [31:0] prog [$];

  // behavioural instruction memory
  always @(posedge clk) begin
    if (bus.mem_we) begin
      bmem[bus.mem_a[AW+1:2]] <= bus.mem_wd;
      n_we <= n_we + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.start = 1'b0; bus.wvalid = 1'b1;
    @(negedge clk); #1;
    chk("rst.core_reset", 32'(bus.core_reset), 1);
    chk("rst.wready",     32'(bus.wready), 0);
    chk("rst.done",       32'(bus.done), 0);
    chk("rst.err",        32'(bus.err), 0);
    chk("rst.mem_we",     32'(bus.mem_we), 0);
    reset = 1'b0; bus.wvalid = 1'b0;
  endtask

  // Issue start, stream prog[] with gmin..gmax idle cycles before each word,
  // then check completion (and the checksum word when enabled).
  task automatic load(input int gmin, input int gmax, input bit bad_sum);
    int n, we0, gap;
    logic [31:0] s;
    n = prog.size(); s = '0; we0 = n_we;
    @(negedge clk);
    bus.start = 1'b1; bus.len = (AW+1)'(n); bus.core_a = $urandom;
    @(negedge clk);
    bus.start = 1'b0; #1;
    chk("load.wready", 32'(bus.wready), 1);
    chk("load.core_reset", 32'(bus.core_reset), 1);
    chk("load.done", 32'(bus.done), 0);
    chk("load.err", 32'(bus.err), 0);
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(gmax, gmin);
      repeat (gap) begin
        chk("gap.mem_we", 32'(bus.mem_we), 0);
        chk("gap.mem_a", bus.mem_a, 32'(4 * i));
        @(negedge clk); #1;
      end
      bus.wvalid = 1'b1; bus.wdata = prog[i]; #1;
      chk("wr.mem_we", 32'(bus.mem_we), 1);
      chk("wr.mem_a", bus.mem_a, 32'(4 * i));
      chk("wr.mem_wd", bus.mem_wd, prog[i]);
      s = s + prog[i];
      @(negedge clk);
      bus.wvalid = 1'b0; #1;
    end
`ifdef IMEM_LOAD_CHECKSUM_EN
    chk("sum.wready", 32'(bus.wready), 1);
    chk("sum.done", 32'(bus.done), 0);
    bus.wvalid = 1'b1; bus.wdata = s + 32'(bad_sum); #1;
    chk("sum.mem_we", 32'(bus.mem_we), 0);
    @(negedge clk);
    bus.wvalid = 1'b0; #1;
    if (bad_sum) begin
      chk("bad.err", 32'(bus.err), 1);
      chk("bad.done", 32'(bus.done), 0);
      chk("bad.core_reset", 32'(bus.core_reset), 1);
      chk("bad.wready", 32'(bus.wready), 0);
    end else begin
      chk("end.done", 32'(bus.done), 1);
      chk("end.core_reset", 32'(bus.core_reset), 0);
      chk("end.err", 32'(bus.err), 0);
    end
`else
    chk("end.done", 32'(bus.done), (bad_sum && 1'b0) ? 0 : 1);
    chk("end.core_reset", 32'(bus.core_reset), 0);
    chk("end.wready", 32'(bus.wready), 0);
    chk("end.err", 32'(bus.err), 0);
`endif
    chk("end.nwrites", 32'(n_we - we0), 32'(n));
    for (int i = 0; i < n; i++) chk("end.mem", bmem[i], prog[i]);
  endtask

  task automatic bad_start(input logic [AW:0] l, input bit in_run);
    @(negedge clk);
    bus.start = 1'b1; bus.len = l;
    @(negedge clk);
    bus.start = 1'b0; #1;
    chk("badlen.err", 32'(bus.err), 1);
    chk("badlen.wready", 32'(bus.wready), 0);
    chk("badlen.done", 32'(bus.done), 32'(in_run));
  endtask

  initial begin
    reset = 1'b0; bus.start = 1'b0; bus.len = '0; bus.wvalid = 1'b0;
    bus.wdata = '0; bus.core_a = '0;
    do_reset();

    // directed 2-word program, back to back then with 3-cycle gaps
    prog = '{32'h0003A437, 32'h7D040413};
    load(0, 0, 1'b0);
    do_reset();
    load(3, 3, 1'b0);

    // core owns the memory port in RUN
    @(negedge clk);
    bus.core_a = 32'h4; bus.wvalid = 1'b1; #1;
    chk("run.mem_a", bus.mem_a, 32'h4);
    chk("run.mem_we", 32'(bus.mem_we), 0);
    bus.wvalid = 1'b0;

`ifdef IMEM_LOAD_CHECKSUM_EN
    load(0, 1, 1'b1);
    load(0, 1, 1'b0);
`endif

    // invalid lengths from IDLE, then a valid single word clears err
    do_reset();
    bad_start('0, 1'b0);
    bad_start(7'd65, 1'b0);
    prog = '{32'hCAFEF00D};
    load(0, 0, 1'b0);

    // invalid start while running keeps RUN
    bad_start(7'd127, 1'b1);

    // reset after the first of four words
    prog = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    @(negedge clk);
    bus.start = 1'b1; bus.len = 7'd4;
    @(negedge clk);
    bus.start = 1'b0; bus.wvalid = 1'b1; bus.wdata = prog[0];
    @(negedge clk);
    bus.wdata = prog[1]; reset = 1'b1;
    @(negedge clk); #1;
    chk("midrst.core_reset", 32'(bus.core_reset), 1);
    chk("midrst.wready", 32'(bus.wready), 0);
    chk("midrst.done", 32'(bus.done), 0);
    chk("midrst.mem_we", 32'(bus.mem_we), 0);
    reset = 1'b0; bus.wvalid = 1'b0;
    load(0, 1, 1'b0);

    // randomized programs, including a full-depth one
    for (int t = 0; t < 8; t++) begin
      int n;
      n = (t == 3) ? DEPTH : int'($urandom_range(12, 1));
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back($urandom);
      load(0, 2, 1'($urandom_range(1, 0)));
      @(negedge clk);
      bus.core_a = $urandom; #1;
      if (bus.done) chk("rnd.mem_a", bus.mem_a, bus.core_a);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter DEPTH, default 64, meaning the number of 32-bit instruction memory words.
REQ-002 The module SHALL have parameter AW, default 6, meaning the word-address width, equal to log2(DEPTH).
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port start  input  1  one-cycle request to begin loading a program.
REQ-006 The module SHALL have port len  input  AW+1  program length in words, sampled with start.
REQ-007 The module SHALL have port wvalid  input  1  host word valid.
REQ-008 The module SHALL have port wdata  input  32  host instruction word.
REQ-009 The module SHALL have port wready  output  1  loader accepts a host word.
REQ-010 The module SHALL have port core_a  input  32  core fetch byte address.
REQ-011 The module SHALL have port mem_a  output  32  byte address to the instruction memory.
REQ-012 The module SHALL have port mem_we  output  1  instruction memory write enable.
REQ-013 The module SHALL have port mem_wd  output  32  instruction memory write data.
REQ-014 The module SHALL have port core_reset  output  1  holds the pipelined core in reset.
REQ-015 The module SHALL have port done  output  1  program loaded, core running.
REQ-016 The module SHALL have port err  output  1  sticky load error.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, CHECK (macro only) and RUN.
REQ-018 In IDLE: core_reset=1, wready=0, done=0; start with 1<=len<=DEPTH latches len, clears cnt and err, and enters LOAD next cycle.
REQ-019 start with len=0 or len>DEPTH SHALL set err=1 and leave the state unchanged.
REQ-020 In LOAD: wready=1, core_reset=1; a transfer is wvalid&wready.
REQ-021 mem_we SHALL equal the transfer combinationally, with mem_a={cnt,2'b00} zero-extended and mem_wd=wdata (zero added latency).
REQ-022 cnt (AW bits) SHALL increment per transfer; a transfer with cnt==len-1 SHALL leave LOAD (to CHECK if the macro is defined, otherwise RUN); cnt never wraps past len-1.
REQ-023 A cycle without wvalid in LOAD SHALL hold cnt and state unchanged.
REQ-024 start during LOAD or CHECK SHALL be ignored.
REQ-025 In IDLE and RUN: mem_a=core_a, mem_we=0, wready=0.
REQ-026 In RUN: core_reset=0, done=1; a valid start SHALL enter LOAD with core_reset=1 and done=0 from the next cycle; an invalid start SHALL set err=1 and stay in RUN.

Reset
REQ-027 reset SHALL take priority over all inputs; on the next edge: state=IDLE, cnt=0, latched len=0, sum=0, err=0, done=0, core_reset=1, wready=0, mem_we=0.
REQ-028 reset mid-LOAD SHALL abandon the load; words already written remain in memory but are not valid until a new load completes.

Configuration
REQ-029 Macro IMEM_LOAD_CHECKSUM_EN, when defined, SHALL add a 32-bit sum register (mod 2^32 sum of the program words written in LOAD) and the CHECK state.
REQ-030 With the macro defined, CHECK SHALL assert wready=1 and mem_we=0; the next transfer is compared with sum: equal goes to RUN; unequal sets err=1 and goes to IDLE with core_reset held at 1.
REQ-031 Without the macro, there SHALL be no sum register and no CHECK state, and err SHALL come only from an invalid len.

Verification
REQ-032 The bench SHALL cover: start, len=2; words 0x0003A437, 0x7D040413 -> writes to addresses 0x0 and 0x4; one cycle after the second transfer (no macro), done=1 and core_reset=0.
REQ-033 The bench SHALL cover: same load with wvalid low for 3 cycles between words -> no extra mem_we; cnt held; identical final writes.
REQ-034 The bench SHALL cover: start with len=0, then with len=65 -> err=1 and state stays IDLE; a following valid start with len=1 -> err=0.
REQ-035 The bench SHALL cover: reset asserted after the first of 4 words -> next cycle IDLE, core_reset=1, wready=0, done=0.
REQ-036 The bench SHALL cover, with the macro: the 2-word program followed by checksum 0x7D07A84A -> RUN; the same program followed by 0x7D07A84B -> err=1, IDLE.
REQ-037 The bench SHALL cover: in RUN, core_a=0x4 -> mem_a=0x4 and mem_we=0.
